checkpoint_monitor: RTL and testbench
=====================================

// Module: checkpoint_monitor
// PURPOSE
//  Synthesizable monitor for the firmware checkpoint bus used by the management SoC tests.
//  Decodes start, pass and fail codes on a multi-bit checkpoint bus, driven from mprj_io[31:16].
//  Sequences a configurable number of test phases and applies a glitch/stability filter.
//  Runs a watchdog timeout and latches a sticky PASS/FAIL/TIMEOUT verdict for an FPGA or
//  on-chip self-test harness.
// PARAMETERS
//  CHK_W          16      checkpoint bus width; must be >= 9; tag field = checkbits[CHK_W-1:8]
//  START_TAG      'hA0    tag value marking "phase started" (CHK_W-8 bits)
//  RESULT_TAG     'hAB    tag value marking "phase result" (CHK_W-8 bits)
//  NUM_PHASES     3       number of passed phases required for overall PASS (1..127)
//  STABLE_CYCLES  4       consecutive identical samples before a value is decoded (>=1)
//  TIMEOUT_CYCLES 100000  watchdog limit, in clocks, between accepted events (>=1)
// PORTS
//  clock        in   1      single system clock; all logic on rising edge
//  reset        in   1      asynchronous, active-high reset
//  enable       in   1      1 = monitor armed; 0 = hold in IDLE, watchdog cleared
//  checkbits    in   CHK_W  checkpoint bus (async to firmware, already in clock domain)
//  cur_phase    out  7      phase id of the most recent accepted start code
//  phase_active out  1      1 while a started phase awaits its result
//  pass_count   out  7      number of phases passed so far (saturates at NUM_PHASES)
//  event_pulse  out  1      one-cycle strobe on every accepted start/result code
//  done         out  1      sticky: verdict reached
//  verdict      out  2      00 none, 01 PASS, 10 FAIL, 11 TIMEOUT (valid when done=1)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, filter and watchdog counters 0.
//  Code format: tag=checkbits[CHK_W-1:8], id=checkbits[7:1], flag=checkbits[0].
//   START  : tag==START_TAG  and flag==0.
//   RESULT : tag==RESULT_TAG; flag=1 pass, flag=0 fail.
//   Any other value: ignored, no event.
//  Filter:
//   - Register a sample each clock; stab_cnt resets to 1 when the sample changes,
//     otherwise increments (saturating).
//   - A value is decoded exactly once: in the cycle stab_cnt reaches STABLE_CYCLES.
//   - A held value never re-decodes; the same code re-fires only after a change and a
//     re-settle.
//   - Latency: event_pulse and state update STABLE_CYCLES+1 clocks after checkbits
//     settles.
//  FSM (decoded event -> next state, registered):
//   IDLE    : enable=0 -> stay.
//             START id -> RUN, cur_phase=id, phase_active=1, event_pulse.
//             RESULT -> DONE, verdict=FAIL (result without start).
//   RUN     : RESULT pass, id==cur_phase -> pass_count+1, phase_active=0, event_pulse;
//               if pass_count+1==NUM_PHASES -> DONE, verdict=PASS; else -> IDLE.
//             RESULT fail (any id) or RESULT with id!=cur_phase -> DONE, verdict=FAIL.
//             START same id -> ignored. START different id -> DONE, verdict=FAIL.
//   DONE    : terminal; done=1, verdict held, all further codes ignored until reset.
//  Watchdog:
//   - Counts clocks while enable=1 and FSM!=DONE; cleared on every accepted event and
//     while enable=0.
//   - When count reaches TIMEOUT_CYCLES-1 with no event: -> DONE, verdict=TIMEOUT.
//   - If a decode event and timeout coincide in one cycle, the event wins and the
//     counter clears.
//  enable deasserted mid-RUN:
//   - FSM -> IDLE; phase_active=0; pass_count and cur_phase kept.
//   - Filter keeps sampling, but no decode while enable=0.
//  Async reset mid-operation: immediate return to reset values, including clearing DONE.
//  Counter widths: stab_cnt $clog2(STABLE_CYCLES+1); watchdog $clog2(TIMEOUT_CYCLES+1).
// TESTING (CHK_W=16, defaults unless stated)
//  1. A040,AB41,A020,AB21,A010,AB11, each held 10 clk
//     -> 6 event_pulses, pass_count 1,2,3, done=1, verdict=01.
//  2. A040 then AB40 -> done=1, verdict=10, pass_count=0; later AB41 ignored.
//  3. A040 held 3 clk then A041 held 10 clk (STABLE_CYCLES=4)
//     -> no event for A040; A041 ignored (flag=1 start invalid), no event_pulse.
//  4. TIMEOUT_CYCLES=50: A040 then no change
//     -> done=1, verdict=11 exactly 50 clk after the A040 event_pulse.
//  5. A040, then reset pulsed, then A020,AB21 -> after reset state IDLE, pass_count=1,
//     cur_phase=0x10, done=0.
//  6. A040 then A020 -> verdict=10. Separately, AB21 from IDLE -> verdict=10.
//     Separately, A040 held 1000 clk with TIMEOUT_CYCLES=2000 -> exactly one event_pulse.

Source files
------------

// File: rtl/checkpoint_monitor.sv
`timescale 1ns/1ps
// Firmware checkpoint bus monitor: stability filter, phase sequencer,
// watchdog and sticky PASS/FAIL/TIMEOUT verdict.
module checkpoint_monitor #(
    parameter int unsigned         CHK_W          = 16,
    parameter logic [CHK_W-9:0]    START_TAG      = 'hA0,
    parameter logic [CHK_W-9:0]    RESULT_TAG     = 'hAB,
    parameter int unsigned         NUM_PHASES     = 3,
    parameter int unsigned         STABLE_CYCLES  = 4,
    parameter int unsigned         TIMEOUT_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CHK_W-1:0] checkbits,
    output logic [6:0]       cur_phase,
    output logic             phase_active,
    output logic [6:0]       pass_count,
    output logic             event_pulse,
    output logic             done,
    output logic [1:0]       verdict
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    PASS_LAST = 7'(NUM_PHASES - 1);

    localparam logic [1:0] V_PASS    = 2'b01;
    localparam logic [1:0] V_FAIL    = 2'b10;
    localparam logic [1:0] V_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CHK_W-1:0] sample_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic             used_q, used_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [6:0]       phase_q, phase_d;
    logic [6:0]       pass_q, pass_d;
    logic [1:0]       verdict_q, verdict_d;
    logic             pulse_q, pulse_d;

    logic             changed;
    logic             settle;
    logic             is_start;
    logic             is_result;
    logic [CHK_W-9:0] tag;
    logic [6:0]       id;
    logic             flag;

    assign tag  = sample_q[CHK_W-1:8];
    assign id   = sample_q[7:1];
    assign flag = sample_q[0];

    // A settled value is decoded once; used_q blocks re-decode while held.
    always_comb begin
        changed = (checkbits != sample_q);
        stab_d  = stab_q;
        used_d  = used_q;
        if (changed) begin
            stab_d = SW'(1);
            used_d = 1'b0;
        end else begin
            if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
            if (stab_q == STAB_MAX) used_d = 1'b1;
        end
        settle    = (stab_q == STAB_MAX) && !used_q;
        is_start  = settle && enable && (tag == START_TAG) && !flag;
        is_result = settle && enable && (tag == RESULT_TAG);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sample_q  <= '0;
            stab_q    <= '0;
            used_q    <= 1'b0;
            wd_q      <= '0;
            phase_q   <= '0;
            pass_q    <= '0;
            verdict_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= checkbits;
            stab_q    <= stab_d;
            used_q    <= used_d;
            wd_q      <= wd_d;
            phase_q   <= phase_d;
            pass_q    <= pass_d;
            verdict_q <= verdict_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pass_d    = pass_q;
        verdict_d = verdict_q;
        pulse_d   = 1'b0;
        wd_d      = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (is_start) begin
                    state_d = S_RUN;
                    phase_d = id;
                    pulse_d = 1'b1;
                end else if (is_result) begin
                    state_d   = S_DONE;
                    verdict_d = V_FAIL;
                    pulse_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (is_result) begin
                    pulse_d = 1'b1;
                    if (flag && (id == phase_q)) begin
                        pass_d = pass_q + 7'd1;
                        if (pass_q == PASS_LAST) begin
                            state_d   = S_DONE;
                            verdict_d = V_PASS;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d   = S_DONE;
                        verdict_d = V_FAIL;
                    end
                end else if (is_start && (id != phase_q)) begin
                    state_d   = S_DONE;
                    verdict_d = V_FAIL;
                    pulse_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // An accepted event in the timeout cycle takes priority.
        if (!enable || (state_q == S_DONE) || pulse_d) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            wd_d      = '0;
            state_d   = S_DONE;
            verdict_d = V_TIMEOUT;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        cur_phase    = phase_q;
        pass_count   = pass_q;
        event_pulse  = pulse_q;
        verdict      = verdict_q;
        done         = (state_q == S_DONE);
        phase_active = (state_q == S_RUN);
    end

endmodule

// File: tb/tb_checkpoint_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for checkpoint_monitor: directed codes, expected
// output snapshots queued by stimulus and popped by per-DUT monitors.
module tb_checkpoint_monitor;

    logic        clock = 1'b0;
    logic        rst_a, rst_b, enable;
    logic [15:0] checkbits;

    logic [6:0] ph_a, pc_a, ph_b, pc_b;
    logic       act_a, ep_a, dn_a, act_b, ep_b, dn_b;
    logic [1:0] vd_a, vd_b;

    always #5 clock = ~clock;

    checkpoint_monitor #(.TIMEOUT_CYCLES(2000)) dut_a (
        .clock(clock), .reset(rst_a), .enable(enable),
        .checkbits(checkbits), .cur_phase(ph_a),
        .phase_active(act_a), .pass_count(pc_a),
        .event_pulse(ep_a), .done(dn_a), .verdict(vd_a)
    );

    checkpoint_monitor #(.TIMEOUT_CYCLES(50)) dut_b (
        .clock(clock), .reset(rst_b), .enable(enable),
        .checkbits(checkbits), .cur_phase(ph_b),
        .phase_active(act_b), .pass_count(pc_b),
        .event_pulse(ep_b), .done(dn_b), .verdict(vd_b)
    );

    typedef struct {
        logic       ep;
        logic [6:0] ph;
        logic       act;
        logic [6:0] pc;
        logic       dn;
        logic [1:0] vd;
        int         at;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses_a = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic check_rec(string nm, rec_t e, logic [18:0] got);
        cmp(nm, {13'd0, got}, {13'd0, e.ep, e.ph, e.act, e.pc, e.dn, e.vd});
        if (e.at >= 0) cmp({nm, "_cycle"}, cyc, e.at);
    endtask

    logic [17:0] last_a = '0;
    logic [17:0] last_b = '0;

    always @(negedge clock) begin
        logic [17:0] np;
        rec_t        e;
        if (rst_a) begin
            last_a = '0;
        end else begin
            np = {ph_a, act_a, pc_a, dn_a, vd_a};
            if (ep_a) pulses_a++;
            if (ep_a || np != last_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_a unexpected output %0h", {ep_a, np});
                end else begin
                    e = qa.pop_front();
                    check_rec("mon_a", e, {ep_a, np});
                end
            end
            last_a = np;
        end
    end

    always @(negedge clock) begin
        logic [17:0] np;
        rec_t        e;
        if (rst_b) begin
            last_b = '0;
        end else begin
            np = {ph_b, act_b, pc_b, dn_b, vd_b};
            if (ep_b || np != last_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_b unexpected output %0h", {ep_b, np});
                end else begin
                    e = qb.pop_front();
                    check_rec("mon_b", e, {ep_b, np});
                end
            end
            last_b = np;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic hold(logic [15:0] v, int n);
        checkbits = v;
        tick(n);
    endtask

    task automatic push_a(logic ep, logic [6:0] ph, logic act,
                          logic [6:0] pc, logic dn, logic [1:0] vd, int at);
        rec_t r;
        r = '{ep: ep, ph: ph, act: act, pc: pc, dn: dn, vd: vd, at: at};
        qa.push_back(r);
    endtask

    task automatic push_b(logic ep, logic [6:0] ph, logic act,
                          logic [6:0] pc, logic dn, logic [1:0] vd, int at);
        rec_t r;
        r = '{ep: ep, ph: ph, act: act, pc: pc, dn: dn, vd: vd, at: at};
        qb.push_back(r);
    endtask

    task automatic reset_a();
        checkbits = '0;
        rst_a = 1'b1;
        tick(3);
        rst_a = 1'b0;
        tick(1);
    endtask

    task automatic drain_a(string nm);
        for (int i = 0; i < 20 && qa.size() != 0; i++) tick(1);
        cmp(nm, qa.size(), 0);
    endtask

    task automatic drain_b(string nm);
        for (int i = 0; i < 20 && qb.size() != 0; i++) tick(1);
        cmp(nm, qb.size(), 0);
    endtask

    initial begin
        int c;
        int p0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        enable    = 1'b0;
        checkbits = '0;
        tick(3);
        rst_a = 1'b0;
        tick(1);

        // reset state
        cmp("rst_cur_phase", ph_a, 0);
        cmp("rst_active", act_a, 0);
        cmp("rst_pass_count", pc_a, 0);
        cmp("rst_pulse", ep_a, 0);
        cmp("rst_done", dn_a, 0);
        cmp("rst_verdict", vd_a, 0);
        enable = 1'b1;

        // full three-phase pass
        c = cyc;
        push_a(1, 7'h20, 1, 0, 0, 2'd0, c + 5);
        hold(16'hA040, 10);
        push_a(1, 7'h20, 0, 1, 0, 2'd0, -1);
        hold(16'hAB41, 10);
        push_a(1, 7'h10, 1, 1, 0, 2'd0, -1);
        hold(16'hA020, 10);
        push_a(1, 7'h10, 0, 2, 0, 2'd0, -1);
        hold(16'hAB21, 10);
        push_a(1, 7'h08, 1, 2, 0, 2'd0, -1);
        hold(16'hA010, 10);
        push_a(1, 7'h08, 0, 3, 1, 2'd1, -1);
        hold(16'hAB11, 10);
        hold(16'hA040, 10);
        drain_a("t1_drain");
        cmp("t1_done", dn_a, 1);
        cmp("t1_verdict", vd_a, 1);
        cmp("t1_pass_count", pc_a, 3);

        // failing result, later codes ignored
        reset_a();
        push_a(1, 7'h20, 1, 0, 0, 2'd0, -1);
        hold(16'hA040, 10);
        push_a(1, 7'h20, 0, 0, 1, 2'd2, -1);
        hold(16'hAB40, 10);
        hold(16'hAB41, 10);
        drain_a("t2_drain");
        cmp("t2_verdict", vd_a, 2);
        cmp("t2_pass_count", pc_a, 0);

        // glitch too short, then invalid start with flag set
        reset_a();
        p0 = pulses_a;
        hold(16'hA040, 3);
        hold(16'hA041, 10);
        drain_a("t3_drain");
        cmp("t3_pulses", pulses_a - p0, 0);
        cmp("t3_done", dn_a, 0);
        cmp("t3_active", act_a, 0);

        // reset mid-run
        reset_a();
        push_a(1, 7'h20, 1, 0, 0, 2'd0, -1);
        hold(16'hA040, 10);
        drain_a("t5_pre_drain");
        reset_a();
        cmp("t5_rst_phase", ph_a, 0);
        cmp("t5_rst_active", act_a, 0);
        cmp("t5_rst_done", dn_a, 0);
        push_a(1, 7'h10, 1, 0, 0, 2'd0, -1);
        hold(16'hA020, 10);
        push_a(1, 7'h10, 0, 1, 0, 2'd0, -1);
        hold(16'hAB21, 10);
        drain_a("t5_drain");
        cmp("t5_pass_count", pc_a, 1);
        cmp("t5_cur_phase", ph_a, 7'h10);
        cmp("t5_done", dn_a, 0);

        // start with different id while running
        reset_a();
        push_a(1, 7'h20, 1, 0, 0, 2'd0, -1);
        hold(16'hA040, 10);
        push_a(1, 7'h20, 0, 0, 1, 2'd2, -1);
        hold(16'hA020, 10);
        drain_a("t6a_drain");

        // result without start
        reset_a();
        push_a(1, 7'h00, 0, 0, 1, 2'd2, -1);
        hold(16'hAB21, 10);
        drain_a("t6b_drain");

        // long hold decodes once
        reset_a();
        p0 = pulses_a;
        push_a(1, 7'h20, 1, 0, 0, 2'd0, -1);
        hold(16'hA040, 1000);
        drain_a("t6c_drain");
        cmp("t6c_pulses", pulses_a - p0, 1);
        cmp("t6c_done", dn_a, 0);

        // enable dropped mid-run
        reset_a();
        push_a(1, 7'h20, 1, 0, 0, 2'd0, -1);
        hold(16'hA040, 10);
        push_a(0, 7'h20, 0, 0, 0, 2'd0, -1);
        enable = 1'b0;
        hold(16'hAB41, 10);
        enable = 1'b1;
        tick(10);
        push_a(1, 7'h10, 1, 0, 0, 2'd0, -1);
        hold(16'hA020, 10);
        drain_a("t7_drain");
        cmp("t7_pass_count", pc_a, 0);

        // watchdog on the short-timeout instance
        checkbits = '0;
        rst_a = 1'b1;
        tick(2);
        c = cyc;
        push_b(1, 7'h20, 1, 0, 0, 2'd0, c + 5);
        push_b(0, 7'h20, 0, 0, 1, 2'd3, c + 55);
        rst_b = 1'b0;
        hold(16'hA040, 80);
        drain_b("t4_drain");
        cmp("t4_done", dn_b, 1);
        cmp("t4_verdict", vd_b, 3);
        rst_b = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
